// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_unit
//  Purpose  : Instruction-fetch front end for the pipelined RV32I core.
//             Issues sequential word-aligned fetches over a request/grant,
//             in-order-response memory interface, buffers returned
//             {pc, inst} pairs in a DEPTH-entry FIFO and hands them to decode
//             with a valid/ready handshake. Redirects flush the FIFO and
//             discard responses that are still in flight; halt stops new
//             requests while letting outstanding ones complete.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH     FIFO entries, power of two, 2..16
//    RESET_PC  address of the first fetch after reset
//  Ports
//    clk, rst_n          clock, synchronous active-low reset
//    imem_req/addr/gnt   fetch request channel (addr word aligned)
//    imem_rvalid/rdata   in-order response channel
//    redirect/_pc        flush and restart fetch at redirect_pc[31:2]
//    halt                blocks new requests while high
//    id_valid/ready      decode handshake
//    id_pc/id_inst       presented instruction and its PC
//    empty               FIFO holds no entries
//  Build option
//    PREFETCH_BYPASS_EN  when defined, a response arriving at an empty FIFO
//                        is presented to decode in the same cycle.
// ============================================================================
module if_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        empty
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_PW = c_AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [c_PW-1:0] outst_q,    outst_d;
    logic [c_PW-1:0] discard_q,  discard_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q,  resp_pc_d;

    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic [c_PW-1:0] w_count;
    logic [c_PW:0]   w_inflight;
    logic            w_fifo_empty;
    logic            w_grant;
    logic            w_keep;
    logic            w_write;
    logic            w_read;
    logic [31:0]     w_target;
    logic [c_AW-1:0] w_wr_idx;
    logic [c_AW-1:0] w_rd_idx;

    assign w_count      = wr_ptr_q - rd_ptr_q;
    assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign w_wr_idx     = wr_ptr_q[c_AW-1:0];
    assign w_rd_idx     = rd_ptr_q[c_AW-1:0];
    assign w_target     = redirect_pc & ~32'h0000_0003;

    // Credit check: queued entries plus in-flight requests may never exceed
    // DEPTH, so every response that comes back is guaranteed a FIFO slot.
    assign w_inflight = {1'b0, w_count} + {1'b0, outst_q};
    assign imem_req   = rst_n && !halt && !redirect
                        && (w_inflight < (c_PW+1)'(DEPTH));
    assign imem_addr  = fetch_pc_q;
    assign w_grant    = imem_req && imem_gnt;

    // A response is kept only when no stale responses remain to be skipped
    // and no redirect is flushing the stream this cycle.
    assign w_keep = imem_rvalid && (discard_q == '0) && !redirect;

`ifdef PREFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass = rst_n && w_fifo_empty && w_keep;
    // A bypassed response consumed by decode never occupies a slot.
    assign w_write  = w_keep && !(w_bypass && id_ready);
    assign id_valid = rst_n && (!w_fifo_empty || w_bypass);
`else
    assign w_write  = w_keep;
    assign id_valid = rst_n && !w_fifo_empty;
`endif

    assign empty  = !rst_n || w_fifo_empty;
    assign w_read = id_valid && id_ready && !w_fifo_empty && !redirect;

    always_comb begin
        id_pc   = 32'h0;
        id_inst = 32'h0;
        if (id_valid) begin
            if (!w_fifo_empty) begin
                id_pc   = pc_mem_q[w_rd_idx];
                id_inst = inst_mem_q[w_rd_idx];
            end else begin
                // Only reachable through the bypass path.
                id_pc   = resp_pc_q;
                id_inst = imem_rdata;
            end
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q + c_PW'(w_write);
        rd_ptr_d   = rd_ptr_q + c_PW'(w_read);
        outst_d    = outst_q + c_PW'(w_grant) - c_PW'(imem_rvalid);
        discard_d  = discard_q;

        if (w_grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (w_keep) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        if (redirect) begin
            fetch_pc_d = w_target;
            resp_pc_d  = w_target;
            rd_ptr_d   = wr_ptr_q;
            // No grant can occur in a redirect cycle, so everything still
            // outstanding after this cycle's response belongs to the old path.
            discard_d  = outst_q - c_PW'(imem_rvalid);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && w_write) begin
            pc_mem_q[w_wr_idx]   <= resp_pc_q;
            inst_mem_q[w_wr_idx] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_prefetch_unit
//  Purpose  : Self-checking bench for if_prefetch_unit. A transaction-level
//             model (queue of outstanding fetches tagged with a flush epoch,
//             queue of buffered PCs) predicts every handshake each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        empty;

    always #5 clk = ~clk;

    if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .empty      (empty)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    req_t        oq[$];      // requests granted but not yet answered
    logic [31:0] fq[$];      // PCs buffered for decode
    logic [31:0] exp_fetch = RPC;
    int          epoch = 0;
    int          cyc   = 0;

    // stimulus knobs
    bit          rst_s = 1'b0;
    bit          halt_s = 1'b0;
    int          gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
    int          lat_min = 1, lat_max = 1;
    bit          redir_now = 1'b0, redir_on_rv = 1'b0, rand_redir = 1'b0;
    logic [31:0] redir_tgt = 32'h0;

    // observations
    int          n_grants = 0, n_deliv = 0;
    int          first_grant = -1, first_valid = -1;
    logic [31:0] dpc [4];
    bit          watch_grant = 1'b0;
    logic [31:0] cap_addr = 32'hDEAD_BEEF;
    logic        last_req = 1'b0, last_valid = 1'b0;

    task automatic cycle();
        bit          rv, keep, byp, exp_req, exp_valid, hs, g;
        logic [31:0] exp_pc, g_addr, tgt;
        req_t        r;
        @(negedge clk);
        rst_n    = rst_s;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        rv = rst_s && (oq.size() > 0) && ($urandom_range(99) < rv_pct);
        if (rv) rv = (oq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(oq[0].addr) : $urandom;
        if (rand_redir && ($urandom_range(99) < 3)) begin
            redir_now = 1'b1;
            redir_tgt = $urandom;
        end
        redirect    = 1'b0;
        redirect_pc = $urandom;
        if (rst_s && (redir_now || (redir_on_rv && rv))) begin
            redirect    = 1'b1;
            redirect_pc = redir_tgt;
            redir_now   = 1'b0;
            redir_on_rv = 1'b0;
            watch_grant = 1'b1;
            cap_addr    = 32'hDEAD_BEEF;
        end
        halt     = halt_s;
        id_ready = ($urandom_range(99) < rdy_pct);
        #1;
        keep      = rst_n && rv && (oq[0].ep == epoch) && !redirect;
        exp_req   = rst_n && !halt && !redirect && (fq.size() + oq.size() < DEPTH);
        exp_valid = rst_n && (fq.size() > 0);
        exp_pc    = (fq.size() > 0) ? fq[0] : 32'h0;
        byp       = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        if (!exp_valid && keep) begin
            byp       = 1'b1;
            exp_valid = 1'b1;
            exp_pc    = oq[0].addr;
        end
`endif
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
        chk("id_valid", 32'(id_valid), 32'(exp_valid));
        chk("empty", 32'(empty), 32'(!(rst_n && fq.size() > 0)));
        if (exp_valid) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_inst", id_inst, mem_word(exp_pc));
        end
        if (!rst_n) begin
            chk("reset_id_pc", id_pc, 32'h0);
            chk("reset_id_inst", id_inst, 32'h0);
        end
        if (id_valid && first_valid < 0) first_valid = cyc;
        last_req   = imem_req;
        last_valid = id_valid;
        g      = imem_req && imem_gnt;
        g_addr = imem_addr;
        hs     = exp_valid && id_ready && !redirect && rst_n;
        tgt    = redirect_pc & ~32'h3;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            oq.delete();
            fq.delete();
            exp_fetch = RPC;
            epoch++;
        end else begin
            if (hs) begin
                if (n_deliv < 4) dpc[n_deliv] = exp_pc;
                n_deliv++;
                if (!byp) void'(fq.pop_front());
            end
            if (rv) begin
                r = oq.pop_front();
                if (keep && !(byp && id_ready)) fq.push_back(r.addr);
            end
            if (redirect) begin
                fq.delete();
                epoch++;
                exp_fetch = tgt;
            end
            if (g) begin
                r.addr = g_addr;
                r.ep   = epoch;
                r.due  = cyc - 1 + $urandom_range(lat_max, lat_min);
                oq.push_back(r);
                exp_fetch = exp_fetch + 32'd4;
                n_grants++;
                if (first_grant < 0) first_grant = cyc - 1;
                if (watch_grant) begin
                    cap_addr    = g_addr;
                    watch_grant = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_s = 1'b0;
        repeat (n) cycle();
        rst_s       = 1'b1;
        n_grants    = 0;
        n_deliv     = 0;
        first_grant = -1;
        first_valid = -1;
        for (int i = 0; i < 4; i++) dpc[i] = 32'hFFFF_FFFF;
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; id_ready = 1'b0;

        // Streaming with 1-cycle memory and decode always ready
        do_reset(3);
        repeat (12) cycle();
`ifdef PREFETCH_BYPASS_EN
        chk("first_valid_latency", 32'(first_valid - first_grant), 32'd1);
`else
        chk("first_valid_latency", 32'(first_valid - first_grant), 32'd2);
`endif
        chk("stream_pc0", dpc[0], 32'h0);
        chk("stream_pc1", dpc[1], 32'h4);
        chk("stream_pc2", dpc[2], 32'h8);
        chk("stream_pc3", dpc[3], 32'hC);

        // Decode stalled: credits cap the number of grants at DEPTH
        do_reset(2);
        rdy_pct = 0;
        repeat (20) cycle();
        chk("stall_grants", 32'(n_grants), 32'(DEPTH));
        chk("stall_req_low", 32'(last_req), 32'd0);
        rdy_pct = 100;
        n_deliv = 0;
        repeat (15) cycle();
        chk("stall_order0", dpc[0], 32'h0);
        chk("stall_order3", dpc[3], 32'hC);

        // Redirect with two requests in flight on a 3-cycle memory
        do_reset(2);
        lat_min = 3; lat_max = 3;
        repeat (2) cycle();
        chk("two_outstanding", 32'(n_grants), 32'd2);
        redir_tgt = 32'h100;
        redir_now = 1'b1;
        n_deliv   = 0;
        repeat (16) cycle();
        chk("redir_first_pc", dpc[0], 32'h100);
        chk("redir_second_pc", dpc[1], 32'h104);

        // Redirect landing together with a response and a decode handshake
        do_reset(2);
        lat_min = 1; lat_max = 1;
        repeat (4) cycle();
        redir_tgt   = 32'h203;
        redir_on_rv = 1'b1;
        for (int i = 0; i < 20 && redir_on_rv; i++) cycle();
        chk("coinc_redirect_fired", 32'(redir_on_rv), 32'd0);
        repeat (5) cycle();
        chk("coinc_next_fetch", cap_addr, 32'h200);

        // Halt with one request outstanding
        do_reset(2);
        lat_min = 3; lat_max = 3;
        cycle();
        halt_s   = 1'b1;
        n_grants = 0;
        n_deliv  = 0;
        repeat (10) cycle();
        chk("halt_no_grants", 32'(n_grants), 32'd0);
        chk("halt_delivered", 32'(n_deliv), 32'd1);
        chk("halt_pc", dpc[0], 32'h0);
        halt_s      = 1'b0;
        watch_grant = 1'b1;
        cap_addr    = 32'hDEAD_BEEF;
        repeat (3) cycle();
        chk("halt_resume_addr", cap_addr, 32'h4);

        // Randomised long run with occasional redirects, then reset mid-stream
        do_reset(2);
        lat_min = 1; lat_max = 3;
        gnt_pct = 70; rv_pct = 70; rdy_pct = 50;
        rand_redir = 1'b1;
        for (int i = 0; i < 3000 && n_deliv < 100; i++) cycle();
        chk("random_deliveries", 32'(n_deliv >= 100), 32'd1);
        rand_redir = 1'b0;
        redir_now  = 1'b0;
        rst_s      = 1'b0;
        cycle();
        chk("mid_reset_valid", 32'(last_valid), 32'd0);
        cycle();
        watch_grant = 1'b1;
        cap_addr    = 32'hDEAD_BEEF;
        gnt_pct     = 100;
        rst_s       = 1'b1;
        repeat (4) cycle();
        chk("post_reset_fetch", cap_addr, RPC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch front end that feeds the decode/control stage of the pipelined RV32I core.
- Generates sequential PCs and issues requests to instruction memory over a request/grant, in-order-response interface.
- Buffers returned {pc, inst} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects from branch/JAL/JALR resolution by flushing the FIFO and discarding in-flight responses; stops fetching on halt (ECALL).

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits[1:0] ignored (forced 0).
- halt  in  1  level; blocks new requests while high.
- id_valid  out  1  an instruction is presented to decode.
- id_ready  in  1  decode accepts this cycle.
- id_pc  out  32  PC of the presented instruction.
- id_inst  out  32  presented instruction.
- empty  out  1  FIFO holds no entries.

Behaviour:
- Reset (rst_n=0 at an edge): fetch_pc=RESET_PC, FIFO empty (wr_ptr=rd_ptr=0), outstanding=0, discard=0.
  - Outputs while in reset: imem_req=0, id_valid=0, empty=1, id_pc=0, id_inst=0.
  - Reset mid-operation drops all queued entries and the in-flight count.
  - Responses arriving within 1 cycle after reset release are ignored only if discard is nonzero, i.e. never. The memory is required to be reset together with this block.
- Request issue:
  - imem_req = !halt && !redirect && (count + outstanding < DEPTH) && rst_n.
  - imem_addr = fetch_pc.
  - When imem_req && imem_gnt: fetch_pc += 4 and outstanding += 1.
  - imem_req is combinational; imem_addr is held stable until grant.
- Credit rule: FIFO occupancy plus outstanding never exceeds DEPTH, so every accepted response has a slot. No overflow path exists.
- Response capture:
  - On imem_rvalid with discard=0: write {resp_pc, imem_rdata} at wr_ptr, wr_ptr++, outstanding -= 1.
  - resp_pc is an internal counter: advanced by 4 per kept response and loaded with the target on redirect.
  - On imem_rvalid with discard>0: discard -= 1, outstanding -= 1, no write.
- Output: id_valid = !empty; id_pc and id_inst come from the rd_ptr entry. On id_valid && id_ready, rd_ptr++.
- Latency: grant at cycle N, rvalid at N+k, id_valid at N+k+1 (registered FIFO).
- Pointers: log2(DEPTH)+1 bits, natural wrap.
  - Full = MSBs differ and the rest are equal.
  - Empty = pointers equal.
  - count = wr_ptr - rd_ptr.
- Redirect (takes priority over everything else in the same cycle):
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO flushed (rd_ptr=wr_ptr); id_valid=0 the following cycle.
  - discard = outstanding after this cycle's decrement.
  - imem_req forced 0 in the redirect cycle.
  - A response in the redirect cycle is dropped.
  - A decode handshake in the redirect cycle is permitted but irrelevant (flushed).
- Simultaneous write and read on a nonempty FIFO: both occur; count is unchanged.
- Halt: no new requests. Outstanding responses are still captured and the FIFO drains normally. Deasserting halt resumes at fetch_pc. Redirect during halt updates fetch_pc.

Optional Feature:
- Macro PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, discard=0 and imem_rvalid=1, then id_valid=1 the same cycle with imem_rdata/resp_pc driven combinationally.
  - If id_ready=1 the entry is not written.
  - If id_ready=0 it is written normally.
  - Latency is rvalid-cycle +0.
- Undefined: the registered path only (+1 cycle), with no combinational path from imem_rvalid to id_valid.

Test Plan:
- Reset release, memory with 1-cycle latency always granting, id_ready=1 -> id_pc sequence 0,4,8,12 with id_inst matching memory; first id_valid 2 cycles after first grant.
- id_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 grants, then imem_req=0. count+outstanding never exceeds 4. After id_ready=1, order is preserved.
- Two requests outstanding (3-cycle latency), redirect to 0x100 -> both responses dropped, first delivered id_pc=0x100, no stale instruction visible.
- Redirect coincident with imem_rvalid and id_ready to redirect_pc=0x203 -> response dropped, next fetch addr 0x200.
- halt=1 with one request outstanding -> response still delivered, no further imem_req. halt=0 -> fetch resumes at the next sequential PC.
- 100 sequential fetches with random id_ready -> pointer wrap exercised, no loss or duplication; rst_n=0 mid-stream -> id_valid=0 and next fetch at RESET_PC.
